// File: rtl/usb_rx_deframer.sv
// Receive deframer for the USB slave-FIFO word stream: hunts for the sync word,
// then forwards a length-prefixed payload through one skid-free register and checks its sum.
module usb_rx_deframer #(
    parameter int              DATA_WIDTH = 16,
    parameter logic [15:0]     SYNC_WORD  = 16'hA55A,
    parameter int              MAX_LEN    = 1024
) (
    input  logic                  i_usb_ifclk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [DATA_WIDTH-1:0] o_pl_data,
    output logic                  o_pl_valid,
    input  logic                  i_pl_ready,
    output logic                  o_pl_sof,
    output logic                  o_pl_eof,
    output logic                  o_frame_ok,
    output logic                  o_frame_err,
    output logic [1:0]            o_err_code,
    output logic [15:0]           o_frame_cnt
);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  alive;
    logic                  rx_fire;
    logic                  pl_fire;
    logic                  len_zero;
    logic                  len_big;
    logic [15:0]           remain;
    logic [DATA_WIDTH-1:0] sum;
    logic                  first;

    // alive keeps ready low through reset and lets it rise on the first edge after release
    assign o_rx_ready = alive & ((state != S_PAYLOAD) | ~o_pl_valid | i_pl_ready);
    assign rx_fire    = i_rx_valid & o_rx_ready;
    assign pl_fire    = o_pl_valid & i_pl_ready;
    assign len_zero   = (i_rx_data == '0);
    assign len_big    = (32'(i_rx_data) > 32'(MAX_LEN));

    always_ff @(posedge i_usb_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_HUNT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT: begin
                if (rx_fire && i_rx_data == SYNC_WORD) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_fire) state_nxt = (len_zero || len_big) ? S_HUNT : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (rx_fire && remain == 16'd1) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (rx_fire) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge i_usb_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alive       <= 1'b0;
            o_pl_data   <= '0;
            o_pl_valid  <= 1'b0;
            o_pl_sof    <= 1'b0;
            o_pl_eof    <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_code  <= 2'd0;
            o_frame_cnt <= 16'd0;
            remain      <= 16'd0;
            sum         <= '0;
            first       <= 1'b0;
        end else begin
            alive       <= 1'b1;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            // a load below overrides this drain, giving bubble-free replacement
            if (pl_fire) o_pl_valid <= 1'b0;
            case (state)
                S_LEN: begin
                    if (rx_fire) begin
                        if (len_zero) begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= 2'd2;
                        end else if (len_big) begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= 2'd3;
                        end else begin
                            remain <= 16'(i_rx_data);
                            sum    <= '0;
                            first  <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_fire) begin
                        o_pl_data  <= i_rx_data;
                        o_pl_valid <= 1'b1;
                        o_pl_sof   <= first;
                        o_pl_eof   <= (remain == 16'd1);
                        first      <= 1'b0;
                        remain     <= remain - 16'd1;
                        sum        <= sum + i_rx_data;
                    end
                end
                S_CSUM: begin
                    if (rx_fire) begin
                        if (i_rx_data == sum) begin
                            o_frame_ok  <= 1'b1;
                            o_frame_cnt <= o_frame_cnt + 16'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Randomized bench for usb_rx_deframer: frames are built as word lists, and the expected
// payload stream and status events are derived from the frame format directly.
module tb_usb_rx_deframer;

    localparam int          MAX_LEN = 1024;
    localparam logic [15:0] SYNC    = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [15:0] o_pl_data;
    logic        o_pl_valid;
    logic        i_pl_ready = 1'b0;
    logic        o_pl_sof, o_pl_eof, o_frame_ok, o_frame_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_frame_cnt;

    always #5 clk = ~clk;

    usb_rx_deframer #(.DATA_WIDTH(16), .SYNC_WORD(SYNC), .MAX_LEN(MAX_LEN)) dut (
        .i_usb_ifclk(clk), .i_rst_n(rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_pl_data(o_pl_data), .o_pl_valid(o_pl_valid), .i_pl_ready(i_pl_ready),
        .o_pl_sof(o_pl_sof), .o_pl_eof(o_pl_eof),
        .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err),
        .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt)
    );

    logic [15:0] inq[$];   // words to feed
    logic [17:0] expq[$];  // {data, sof, eof} expected on the payload port
    int          stq[$];   // expected status: 0 ok, else error code
    logic [15:0] cntq[$];  // expected frame count at each status pulse
    logic [15:0] pl[$];    // payload under construction
    logic [15:0] model_cnt = 16'd0;
    int          last_err = 0;
    bit          bp_mode = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_raw(input logic [15:0] w);
        inq.push_back(w);
    endtask

    // frame from pl[]; csum defaults to the true sum unless overridden
    task automatic add_frame(input bit force_csum, input logic [15:0] csum_in);
        logic [15:0] s;
        logic [15:0] c;
        s = 16'd0;
        inq.push_back(SYNC);
        inq.push_back(16'(pl.size()));
        for (int i = 0; i < pl.size(); i++) begin
            inq.push_back(pl[i]);
            s = s + pl[i];
            expq.push_back({pl[i], i == 0, i == pl.size() - 1});
        end
        c = force_csum ? csum_in : s;
        inq.push_back(c);
        if (c == s) begin
            model_cnt = model_cnt + 16'd1;
            stq.push_back(0);
        end else begin
            stq.push_back(1);
            last_err = 1;
        end
        cntq.push_back(model_cnt);
    endtask

    task automatic add_badlen(input logic [15:0] len);
        inq.push_back(SYNC);
        inq.push_back(len);
        last_err = (len == 16'd0) ? 2 : 3;
        stq.push_back(last_err);
        cntq.push_back(model_cnt);
    endtask

    task automatic run(input int max_cycles);
        int          cyc = 0;
        int          quiet = 0;
        int          busy;
        bit          stalled = 1'b0;
        logic [17:0] held = '0;
        int          obs;
        while (quiet < 4) begin
            @(negedge clk);
            i_pl_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rx_valid = (inq.size() > 0) && ($urandom_range(0, 3) != 0);
            i_rx_data  = (inq.size() > 0) ? inq[0] : 16'($urandom);
            #1;
            if (stalled)
                chk("stall_hold", 32'({o_pl_valid, o_pl_data, o_pl_sof, o_pl_eof}), 32'({1'b1, held}));
            stalled = 1'b0;
            if (o_frame_ok || o_frame_err) begin
                chk("ok_err_excl", 32'(o_frame_ok & o_frame_err), 32'd0);
                if (stq.size() == 0) chk("unexp_status", 32'({o_frame_ok, o_frame_err}), 32'd0);
                else begin
                    obs = o_frame_ok ? 0 : int'(o_err_code);
                    chk("status", 32'(obs), 32'(stq.pop_front()));
                    chk("frame_cnt", 32'(o_frame_cnt), 32'(cntq.pop_front()));
                end
            end
            if (o_pl_valid) begin
                if (i_pl_ready) begin
                    if (expq.size() == 0) chk("unexp_word", 32'(o_pl_valid), 32'd0);
                    else chk("payload", 32'({o_pl_data, o_pl_sof, o_pl_eof}), 32'(expq.pop_front()));
                end else begin
                    stalled = 1'b1;
                    held = {o_pl_data, o_pl_sof, o_pl_eof};
                end
            end
            if (i_rx_valid && o_rx_ready) void'(inq.pop_front());
            busy  = inq.size() + expq.size() + stq.size();
            quiet = (busy != 0) ? 0 : quiet + 1;
            cyc++;
            if (cyc > max_cycles) begin
                chk("timeout", 32'(busy), 32'd0);
                inq.delete(); expq.delete(); stq.delete(); cntq.delete();
                break;
            end
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
        chk({tag, "_pl"}, 32'({o_pl_data, o_pl_valid, o_pl_sof, o_pl_eof}), 32'd0);
        chk({tag, "_status"}, 32'({o_frame_ok, o_frame_err, o_err_code}), 32'd0);
        chk({tag, "_cnt"}, 32'(o_frame_cnt), 32'd0);
    endtask

    initial begin
        int          len;
        logic [15:0] s;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed frames
        bp_mode = 1'b0;
        pl = {16'h0001, 16'h0002, 16'h0003};
        add_frame(1'b1, 16'h0006);
        run(200);
        chk("err_code_none", 32'(o_err_code), 32'd0);
        add_frame(1'b1, 16'h0007);
        add_badlen(16'h0000);
        pl = {16'h0010, 16'h0020};
        add_frame(1'b0, 16'h0);
        add_badlen(16'h0401);
        pl = {16'h1111};
        add_frame(1'b0, 16'h0);
        add_raw(16'h1234);
        add_raw(16'hFFFF);
        pl = {SYNC, 16'h0001};
        add_frame(1'b1, 16'hA55B);
        pl = {16'hBEEF};
        add_frame(1'b1, 16'hBEEF);
        run(2000);
        chk("err_code_hold", 32'(o_err_code), 32'(last_err));

        // random frames under backpressure
        bp_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            repeat ($urandom_range(0, 2)) begin
                s = 16'($urandom);
                if (s == SYNC) s = 16'h0000;
                add_raw(s);
            end
            if ($urandom_range(0, 19) == 0) begin
                add_badlen(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAX_LEN + 1, 65535)));
            end else begin
                len = $urandom_range(1, 64);
                pl.delete();
                s = 16'd0;
                for (int i = 0; i < len; i++) begin
                    pl.push_back(16'($urandom));
                    s = s + pl[i];
                end
                if ($urandom_range(0, 6) == 0) add_frame(1'b1, s + 16'($urandom_range(1, 65535)));
                else add_frame(1'b0, 16'h0);
            end
        end
        run(40000);
        chk("err_code_rand", 32'(o_err_code), 32'(last_err));

        // reset in the middle of a payload, after 2 of 5 words
        bp_mode = 1'b0;
        inq.push_back(SYNC);
        inq.push_back(16'd5);
        inq.push_back(16'h0A0A);
        inq.push_back(16'h0B0B);
        expq.push_back({16'h0A0A, 1'b1, 1'b0});
        expq.push_back({16'h0B0B, 1'b0, 1'b0});
        run(200);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_cnt = 16'd0;
        last_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pl = {16'h0003, 16'h0004, 16'h0005};
        add_frame(1'b0, 16'h0);
        run(200);
        chk("cnt_after_reset", 32'(o_frame_cnt), 32'd1);
        chk("err_after_reset", 32'(o_err_code), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
